mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
- Game-sequencing FSM for the whack-a-box datapath.
- Sequences each game:
  - starts a game and requests the per-level board draw;
  - arms each round (advances the LFSR via go);
  - times the hit window, whose length shrinks with level;
  - captures one sensor strike per round and issues a one-cycle judged-hit pulse for score update;
  - steps rounds and levels, and flags game over.
- Sits between the ultrasonic sensor decoder, the datapath, and the audio block.

Parameters:
- HIT_WINDOW, 25_000_000, base hit-window length in clocks (level 0); level n uses HIT_WINDOW >> n.
- GAP_TICKS, 12_500_000, clocks between the end of a judge and the next arm.
- LEVEL_ROUNDS, 10, rounds per level (1..15).
- NUM_LEVELS, 3, number of levels (1..4).
- AUDIO_TICKS, 5_000_000, audio_en high time after a correct hit.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-low: reset==0 at a posedge resets the block.
- start, in, 1, player start button; level-sensitive, rising edge detected internally.
- draw_done, in, 1, datapath level-draw complete.
- box_address, in, 3, struck box from sensors; 0 = none.
- target_box, in, 3, currently populated box from datapath; 0 = none.
- go, out, 1, one-cycle LFSR advance pulse.
- draw_en, out, 1, board draw request.
- hit_valid, out, 1, one-cycle judge pulse.
- hit_correct, out, 1, qualifies hit_valid.
- level, out, 2, current level.
- round_cnt, out, 4, round index within level.
- audio_en, out, 1, correct-hit sound enable.
- game_over, out, 1, game finished.
- state, out, 3, FSM state (debug).

Behaviour:
- Reset (reset==0 at posedge), including mid-operation:
  - state=IDLE; all outputs 0; level=0; round_cnt=0;
  - counters cleared; start_q=0; box_q=0.
- Registered history: start_q<=start and box_q<=box_address every cycle.
  - start_rise = start & ~start_q.
  - strike = (box_address!=0) & (box_address!=box_q).
- States, with state encoding:
  - IDLE (0): all outputs 0. On start_rise: level<=0, round_cnt<=0, go to DRAW.
  - DRAW (1): draw_en=1 (Moore). When draw_done=1, go to ARM next cycle. No timeout.
  - ARM (2): exactly one cycle.
    - go=1.
    - win_cnt <= (HIT_WINDOW >> level) - 1.
    - Go to WINDOW.
  - WINDOW (3): win_cnt decrements each cycle.
    - If strike: latch strike_box<=box_address, go to JUDGE.
    - Else if win_cnt==0: strike_box<=0, go to JUDGE.
    - Strike and win_cnt==0 in the same cycle: strike wins.
  - JUDGE (4): exactly one cycle.
    - hit_valid=1.
    - hit_correct = (strike_box==target_box) & (target_box!=0); a miss (strike_box=0) is never correct.
    - If hit_correct: load aud_cnt<=AUDIO_TICKS.
    - If round_cnt==LEVEL_ROUNDS-1 and level==NUM_LEVELS-1: go to OVER.
    - Else if round_cnt==LEVEL_ROUNDS-1: round_cnt<=0, level<=level+1, gap_cnt<=GAP_TICKS-1, next=DRAW after gap.
    - Else: round_cnt<=round_cnt+1, gap_cnt<=GAP_TICKS-1, next=ARM after gap.
  - GAP (5): gap_cnt decrements; at 0, go to the latched next state (DRAW on level change, ARM otherwise).
  - OVER (6): game_over=1. On start_rise: clear level and round_cnt, game_over=0, go to DRAW (new game).
- Output timing:
  - go and hit_valid are single-cycle pulses; never asserted together.
  - Datapath samples score on hit_valid.
- audio_en:
  - High while aud_cnt!=0; aud_cnt decrements independently of state.
  - A new correct hit reloads aud_cnt (extends, no overlap error).
  - Cleared only by reset; continues into OVER.
- Counter widths:
  - win_cnt, gap_cnt, aud_cnt: 26 bits, unsigned.
  - HIT_WINDOW>>level must be ≥1; a parameter check rejects 0.
- Stuck sensor: a held nonzero box_address produces only one strike; a second strike needs a release to 0 or a different box.
- start held high does not restart the game from OVER; it needs a fresh rising edge.
- Illegal state encodings (7) go to IDLE.

Test Plan:
Bench parameters: HIT_WINDOW=16, GAP_TICKS=4, LEVEL_ROUNDS=2, NUM_LEVELS=2, AUDIO_TICKS=3.
- Reset/start: reset=0 for 2 clocks, then reset=1, start pulse → state 0→1, draw_en=1. draw_done=1 → ARM with go=1 for exactly 1 cycle → WINDOW.
- Correct hit: target_box=2, box_address=2 on the 5th WINDOW cycle → next cycle hit_valid=1, hit_correct=1; audio_en high exactly 3 cycles; round_cnt=1 after JUDGE; GAP lasts 4 cycles, then ARM.
- Timeout/miss: no strike → JUDGE exactly 16 cycles after ARM at level 0, hit_valid=1, hit_correct=0. Same check at level 1 → 8 cycles.
- Level/game flow:
  - round 1 of level 0 ends → level=1, round_cnt=0, path GAP→DRAW;
  - last round of level 1 → OVER, game_over=1;
  - start held high gives no restart; release then press → DRAW, level=0.
- Stuck/simultaneous:
  - box_address held at 5 across two rounds → only the first round gets a strike; the second times out.
  - strike on the cycle win_cnt==0 → judged as a strike (hit_correct per target).
- Reset mid-WINDOW: reset=0 for one clock → state=IDLE, audio_en=0, level=0, round_cnt=0, all pulses 0.

Source files
------------

// File: rtl/mole_round_ctrl_if.sv
// mole_round_ctrl_if
// Groups the signals between the round controller and the datapath.
//   master (controller side): drives go, draw_en, hit_valid, hit_correct,
//                             level, round_cnt; reads draw_done, target_box
//   slave  (datapath side)  : the mirror image
//   go          - one-cycle LFSR advance pulse
//   draw_en     - board draw request
//   draw_done   - datapath finished drawing the level board
//   hit_valid   - one-cycle judge pulse, the datapath samples the score on it
//   hit_correct - qualifies hit_valid
//   target_box  - currently populated box, 0 = none
//   level       - current level
//   round_cnt   - round index within the level
interface mole_round_ctrl_if;
    logic       go;
    logic       draw_en;
    logic       draw_done;
    logic       hit_valid;
    logic       hit_correct;
    logic [2:0] target_box;
    logic [1:0] level;
    logic [3:0] round_cnt;

    modport master (
        output go, draw_en, hit_valid, hit_correct, level, round_cnt,
        input  draw_done, target_box
    );

    modport slave (
        input  go, draw_en, hit_valid, hit_correct, level, round_cnt,
        output draw_done, target_box
    );
endinterface

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl
// Game-sequencing FSM for the whack-a-box game. It starts a game, requests
// the board draw for each level, arms every round, times the hit window
// (which halves with each level), judges one sensor strike per round,
// then steps rounds and levels until the game is over.
// Ports:
//   clock       - system clock
//   reset       - synchronous, active low
//   start       - player start button, level signal; its rising edge is used
//   box_address - struck box from the sensor decoder, 0 = none
//   dp          - datapath handshake (see mole_round_ctrl_if)
//   audio_en    - correct-hit sound enable
//   game_over   - game finished
//   state       - FSM state, for debug
module mole_round_ctrl #(
    parameter int HIT_WINDOW   = 25_000_000,
    parameter int GAP_TICKS    = 12_500_000,
    parameter int LEVEL_ROUNDS = 10,
    parameter int NUM_LEVELS   = 3,
    parameter int AUDIO_TICKS  = 5_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               box_address,
    mole_round_ctrl_if.master        dp,
    output logic                     audio_en,
    output logic                     game_over,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAW   = 3'd1,
        ARM    = 3'd2,
        WINDOW = 3'd3,
        JUDGE  = 3'd4,
        GAP    = 3'd5,
        OVER   = 3'd6
    } state_t;

    localparam logic [25:0] WIN_BASE   = 26'(HIT_WINDOW);
    localparam logic [25:0] GAP_LOAD   = 26'(GAP_TICKS - 1);
    localparam logic [25:0] AUD_LOAD   = 26'(AUDIO_TICKS);
    localparam logic [3:0]  LAST_ROUND = 4'(LEVEL_ROUNDS - 1);
    localparam logic [1:0]  LAST_LEVEL = 2'(NUM_LEVELS - 1);

    // The last level must still have a window of at least one clock, and all
    // counts have to fit the 26-bit counters.
    if (LEVEL_ROUNDS < 1 || LEVEL_ROUNDS > 15) begin : g_bad_rounds
        $error("mole_round_ctrl: LEVEL_ROUNDS must be 1..15");
    end
    if (NUM_LEVELS < 1 || NUM_LEVELS > 4) begin : g_bad_levels
        $error("mole_round_ctrl: NUM_LEVELS must be 1..4");
    end
    if ((HIT_WINDOW >> (NUM_LEVELS - 1)) < 1 || HIT_WINDOW >= (1 << 26)) begin : g_bad_window
        $error("mole_round_ctrl: HIT_WINDOW >> level must be >= 1 and fit 26 bits");
    end
    if (GAP_TICKS < 1 || GAP_TICKS >= (1 << 26) || AUDIO_TICKS < 0 || AUDIO_TICKS >= (1 << 26)) begin : g_bad_ticks
        $error("mole_round_ctrl: GAP_TICKS/AUDIO_TICKS out of range");
    end

    state_t      cur_state;
    state_t      nxt_state;
    state_t      gap_next;
    logic        start_q;
    logic [2:0]  box_q;
    logic [2:0]  strike_box;
    logic [25:0] win_cnt;
    logic [25:0] gap_cnt;
    logic [25:0] aud_cnt;
    logic [1:0]  level_q;
    logic [3:0]  round_q;
    logic        go_q;
    logic        draw_en_q;
    logic        hit_valid_q;
    logic        game_over_q;
    logic        start_rise;
    logic        strike;
    logic        last_round;
    logic        last_level;
    logic        judged_correct;

    // A held box only strikes once: it must change or go back to 0 first.
    assign start_rise     = start & ~start_q;
    assign strike         = (box_address != 3'd0) && (box_address != box_q);
    assign last_round     = (round_q == LAST_ROUND);
    assign last_level     = (level_q == LAST_LEVEL);
    // Judged against the target present during the judge cycle itself;
    // a miss leaves strike_box at 0 and is never correct.
    assign judged_correct = (cur_state == JUDGE) && (strike_box == dp.target_box)
                          && (dp.target_box != 3'd0);

    assign dp.go          = go_q;
    assign dp.draw_en     = draw_en_q;
    assign dp.hit_valid   = hit_valid_q;
    assign dp.hit_correct = judged_correct;
    assign dp.level       = level_q;
    assign dp.round_cnt   = round_q;
    assign audio_en       = (aud_cnt != 26'd0);
    assign game_over      = game_over_q;
    assign state          = cur_state;

    // Next-state decision; a strike on the last window cycle beats the timeout.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (start_rise) nxt_state = DRAW;
            DRAW:    if (dp.draw_done) nxt_state = ARM;
            ARM:     nxt_state = WINDOW;
            WINDOW:  if (strike || win_cnt == 26'd0) nxt_state = JUDGE;
            JUDGE:   nxt_state = (last_round && last_level) ? OVER : GAP;
            GAP:     if (gap_cnt == 26'd0) nxt_state = gap_next;
            OVER:    if (start_rise) nxt_state = DRAW;
            default: nxt_state = IDLE;
        endcase
    end

    // State, counters and Moore outputs; outputs are registered from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_state   <= IDLE;
            gap_next    <= IDLE;
            start_q     <= 1'b0;
            box_q       <= 3'd0;
            strike_box  <= 3'd0;
            win_cnt     <= 26'd0;
            gap_cnt     <= 26'd0;
            aud_cnt     <= 26'd0;
            level_q     <= 2'd0;
            round_q     <= 4'd0;
            go_q        <= 1'b0;
            draw_en_q   <= 1'b0;
            hit_valid_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            start_q     <= start;
            box_q       <= box_address;
            cur_state   <= nxt_state;
            go_q        <= (nxt_state == ARM);
            draw_en_q   <= (nxt_state == DRAW);
            hit_valid_q <= (nxt_state == JUDGE);
            game_over_q <= (nxt_state == OVER);

            // The sound runs on regardless of the game state; a new correct
            // hit simply restarts it.
            if (judged_correct) begin
                aud_cnt <= AUD_LOAD;
            end else if (aud_cnt != 26'd0) begin
                aud_cnt <= aud_cnt - 26'd1;
            end

            case (cur_state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        level_q <= 2'd0;
                        round_q <= 4'd0;
                    end
                end
                ARM: win_cnt <= (WIN_BASE >> level_q) - 26'd1;
                WINDOW: begin
                    if (win_cnt != 26'd0) begin
                        win_cnt <= win_cnt - 26'd1;
                    end
                    if (strike) begin
                        strike_box <= box_address;
                    end else if (win_cnt == 26'd0) begin
                        strike_box <= 3'd0;
                    end
                end
                JUDGE: begin
                    if (!(last_round && last_level)) begin
                        gap_cnt <= GAP_LOAD;
                        if (last_round) begin
                            round_q  <= 4'd0;
                            level_q  <= level_q + 2'd1;
                            gap_next <= DRAW;
                        end else begin
                            round_q  <= round_q + 4'd1;
                            gap_next <= ARM;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt != 26'd0) begin
                        gap_cnt <= gap_cnt - 26'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl
// Bench for mole_round_ctrl with small timing parameters. A behavioural
// game model advanced on every rising edge predicts all outputs, and a
// compare process checks them on every falling edge. A directed game walk
// pins the model with hand-computed values, then random play follows.
module tb_mole_round_ctrl;

    localparam int HIT_WINDOW   = 16;
    localparam int GAP_TICKS    = 4;
    localparam int LEVEL_ROUNDS = 2;
    localparam int NUM_LEVELS   = 2;
    localparam int AUDIO_TICKS  = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_DRAW   = 1;
    localparam int PH_ARM    = 2;
    localparam int PH_WINDOW = 3;
    localparam int PH_JUDGE  = 4;
    localparam int PH_GAP    = 5;
    localparam int PH_OVER   = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] box_address = 3'd0;
    logic       draw_done = 1'b0;
    logic [2:0] target_box = 3'd0;
    logic       audio_en;
    logic       game_over;
    logic [2:0] state;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model of the game: phase, position in the game, and remaining times.
    int m_phase    = PH_IDLE;
    int m_level    = 0;
    int m_round    = 0;
    int m_aud      = 0;
    int m_elapsed  = 0;
    int m_gap_left = 0;
    int m_after    = PH_IDLE;
    int m_sbox     = 0;
    int m_start_h  = 0;
    int m_box_h    = 0;
    bit m_valid    = 1'b0;

    mole_round_ctrl_if dp_if ();
    assign dp_if.draw_done  = draw_done;
    assign dp_if.target_box = target_box;

    mole_round_ctrl #(
        .HIT_WINDOW   (HIT_WINDOW),
        .GAP_TICKS    (GAP_TICKS),
        .LEVEL_ROUNDS (LEVEL_ROUNDS),
        .NUM_LEVELS   (NUM_LEVELS),
        .AUDIO_TICKS  (AUDIO_TICKS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .box_address (box_address),
        .dp          (dp_if),
        .audio_en    (audio_en),
        .game_over   (game_over),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Advances the game model by one clock using the inputs seen at the edge.
    task automatic modelStep();
        int rise;
        int strike;
        int aud_next;
        int win_len;
        if (!reset) begin
            m_phase = PH_IDLE; m_level = 0; m_round = 0; m_aud = 0;
            m_elapsed = 0; m_gap_left = 0; m_after = PH_IDLE; m_sbox = 0;
            m_start_h = 0; m_box_h = 0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        rise     = (start && m_start_h == 0) ? 1 : 0;
        strike   = (box_address != 3'd0 && int'(box_address) != m_box_h) ? 1 : 0;
        aud_next = (m_aud > 0) ? m_aud - 1 : 0;
        case (m_phase)
            PH_IDLE, PH_OVER: begin
                if (rise != 0) begin
                    m_level = 0; m_round = 0; m_phase = PH_DRAW;
                end
            end
            PH_DRAW: if (draw_done) m_phase = PH_ARM;
            PH_ARM: begin
                m_elapsed = 0; m_phase = PH_WINDOW;
            end
            PH_WINDOW: begin
                win_len = HIT_WINDOW / (1 << m_level);
                m_elapsed++;
                if (strike != 0) begin
                    m_sbox = int'(box_address); m_phase = PH_JUDGE;
                end else if (m_elapsed >= win_len) begin
                    m_sbox = 0; m_phase = PH_JUDGE;
                end
            end
            PH_JUDGE: begin
                if (m_sbox == int'(target_box) && target_box != 3'd0) aud_next = AUDIO_TICKS;
                if (m_round == LEVEL_ROUNDS - 1 && m_level == NUM_LEVELS - 1) begin
                    m_phase = PH_OVER;
                end else begin
                    m_gap_left = GAP_TICKS;
                    m_phase    = PH_GAP;
                    if (m_round == LEVEL_ROUNDS - 1) begin
                        m_round = 0; m_level++; m_after = PH_DRAW;
                    end else begin
                        m_round++; m_after = PH_ARM;
                    end
                end
            end
            PH_GAP: begin
                m_gap_left--;
                if (m_gap_left == 0) m_phase = m_after;
            end
            default: m_phase = PH_IDLE;
        endcase
        m_aud     = aud_next;
        m_start_h = start ? 1 : 0;
        m_box_h   = int'(box_address);
    endtask

    // Compares every DUT output with the model's prediction.
    task automatic checkOutput();
        int exp_hc;
        exp_hc = (m_phase == PH_JUDGE && m_sbox == int'(target_box) && target_box != 3'd0) ? 1 : 0;
        checkValue("model state",       int'(state),             m_phase);
        checkValue("model go",          int'(dp_if.go),          (m_phase == PH_ARM)   ? 1 : 0);
        checkValue("model draw_en",     int'(dp_if.draw_en),     (m_phase == PH_DRAW)  ? 1 : 0);
        checkValue("model hit_valid",   int'(dp_if.hit_valid),   (m_phase == PH_JUDGE) ? 1 : 0);
        checkValue("model hit_correct", int'(dp_if.hit_correct), exp_hc);
        checkValue("model level",       int'(dp_if.level),       m_level);
        checkValue("model round_cnt",   int'(dp_if.round_cnt),   m_round);
        checkValue("model audio_en",    int'(audio_en),          (m_aud != 0) ? 1 : 0);
        checkValue("model game_over",   int'(game_over),         (m_phase == PH_OVER)  ? 1 : 0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) checkOutput();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Waits for a given state with a cycle budget; cycles counts the clocks taken.
    task automatic waitState(input int s, input int budget, input string name, output int cycles);
        cycles = 0;
        while (int'(state) != s && cycles < budget) begin
            tick(1);
            cycles++;
        end
        if (int'(state) != s) checkValue({name, " timeout"}, int'(state), s);
    endtask

    // Random play: occasional resets, start toggles, sensor strikes and targets.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            reset     = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 15) == 0) start = ~start;
            draw_done = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0:       box_address = 3'($urandom_range(0, 7));
                1, 2:    box_address = 3'd0;
                3:       box_address = target_box;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) target_box = 3'($urandom_range(0, 7));
            tick(1);
        end
    endtask

    initial begin
        int cycles;

        // Reset and start
        reset = 1'b0;
        tick(2);
        checkValue("reset state", int'(state), 0);
        checkValue("reset level", int'(dp_if.level), 0);
        checkValue("reset audio", int'(audio_en), 0);
        reset = 1'b1;
        tick(1);
        start = 1'b1;
        tick(1);
        checkValue("start state", int'(state), 1);
        checkValue("start draw_en", int'(dp_if.draw_en), 1);
        start = 1'b0;
        draw_done = 1'b1;
        tick(1);
        checkValue("arm state", int'(state), 2);
        checkValue("arm go", int'(dp_if.go), 1);
        draw_done = 1'b0;
        tick(1);
        checkValue("window state", int'(state), 3);
        checkValue("go one cycle", int'(dp_if.go), 0);

        // Correct hit on the 5th window cycle
        target_box = 3'd2;
        tick(4);
        box_address = 3'd2;
        tick(1);
        checkValue("hit judge state", int'(state), 4);
        checkValue("hit hit_valid", int'(dp_if.hit_valid), 1);
        checkValue("hit hit_correct", int'(dp_if.hit_correct), 1);
        box_address = 3'd0;
        tick(1);
        checkValue("hit gap state", int'(state), 5);
        checkValue("hit round_cnt", int'(dp_if.round_cnt), 1);
        checkValue("audio cycle 1", int'(audio_en), 1);
        tick(1);
        checkValue("audio cycle 2", int'(audio_en), 1);
        tick(1);
        checkValue("audio cycle 3", int'(audio_en), 1);
        tick(1);
        checkValue("audio off", int'(audio_en), 0);
        checkValue("gap cycle 4", int'(state), 5);
        tick(1);
        checkValue("gap to arm", int'(state), 2);

        // Timeout at level 0, last round of the level
        waitState(4, 40, "lvl0 judge", cycles);
        checkValue("lvl0 window length", cycles - 1, 16);
        checkValue("lvl0 miss hit_correct", int'(dp_if.hit_correct), 0);
        tick(4);
        checkValue("lvl0 gap", int'(state), 5);
        tick(1);
        checkValue("gap to draw", int'(state), 1);
        checkValue("level up", int'(dp_if.level), 1);
        checkValue("level up round", int'(dp_if.round_cnt), 0);

        // Timeout at level 1
        draw_done = 1'b1;
        tick(1);
        draw_done = 1'b0;
        waitState(4, 40, "lvl1 judge", cycles);
        checkValue("lvl1 window length", cycles - 1, 8);
        checkValue("lvl1 miss hit_valid", int'(dp_if.hit_valid), 1);
        waitState(2, 10, "lvl1 rearm", cycles);

        // Last round: strike on the final window cycle, start held meanwhile
        start = 1'b1;
        tick(1);
        target_box = 3'd3;
        tick(7);
        box_address = 3'd3;
        tick(1);
        checkValue("edge strike hit_valid", int'(dp_if.hit_valid), 1);
        checkValue("edge strike hit_correct", int'(dp_if.hit_correct), 1);
        box_address = 3'd0;
        tick(1);
        checkValue("over state", int'(state), 6);
        checkValue("over game_over", int'(game_over), 1);
        tick(3);
        checkValue("held start no restart", int'(state), 6);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        checkValue("restart state", int'(state), 1);
        checkValue("restart level", int'(dp_if.level), 0);
        checkValue("restart game_over", int'(game_over), 0);
        start = 1'b0;

        // Stuck sensor across two rounds
        draw_done = 1'b1;
        tick(1);
        draw_done = 1'b0;
        target_box = 3'd5;
        tick(1);
        box_address = 3'd5;
        tick(1);
        checkValue("stuck first hit_correct", int'(dp_if.hit_correct), 1);
        waitState(2, 10, "stuck rearm", cycles);
        waitState(4, 40, "stuck judge", cycles);
        checkValue("stuck window length", cycles - 1, 16);
        checkValue("stuck second hit_correct", int'(dp_if.hit_correct), 0);
        box_address = 3'd0;

        // Reset in the middle of a window
        waitState(1, 10, "stuck draw", cycles);
        draw_done = 1'b1;
        tick(1);
        draw_done = 1'b0;
        tick(3);
        checkValue("pre-reset window", int'(state), 3);
        reset = 1'b0;
        tick(1);
        checkValue("mid reset state", int'(state), 0);
        checkValue("mid reset level", int'(dp_if.level), 0);
        checkValue("mid reset round", int'(dp_if.round_cnt), 0);
        checkValue("mid reset audio", int'(audio_en), 0);
        checkValue("mid reset pulses", int'({dp_if.go, dp_if.hit_valid, dp_if.draw_en, game_over}), 0);
        reset = 1'b1;
        tick(1);

        applyStimulus(3000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
